// File: rtl/wrr_arbiter.sv
// Weighted round-robin packet arbiter: grants one requester at a time for up to
// `weight` packets per turn, re-arbitrating on the cycle of each end-of-packet beat.
module wrr_arbiter #(
  parameter int N     = 4,
  parameter int WW    = 4,
  parameter int LOG_N = $clog2(N)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N-1:0]      req_i,
  input  logic [N-1:0]      last_i,
  input  logic [N*WW-1:0]   weight_i,
  input  logic              ready_i,
  output logic [N-1:0]      gnt_o,
  output logic [LOG_N-1:0]  gnt_idx_o,
  output logic              gnt_valid_o
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [LOG_N:0]   NUM_REQ  = (LOG_N+1)'(N);
  localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N-1);

  state_t           state;
  state_t           state_next;
  logic [LOG_N-1:0] ptr;
  logic [LOG_N-1:0] ptr_next;
  logic [LOG_N-1:0] idx_next;
  logic [N-1:0]     gnt_next;
  logic [WW-1:0]    credit;
  logic [WW-1:0]    credit_next;
  logic [WW-1:0]    credit_dec;

  logic             found;
  logic [LOG_N-1:0] winner;
  logic [LOG_N:0]   cand;
  logic [N-1:0]     win_onehot;
  logic [WW-1:0]    win_weight;
  logic [WW-1:0]    win_credit;
  logic [LOG_N-1:0] win_ptr;

  logic             xfer;
  logic             eop;

  // Rotating priority search: first requester at or after ptr, wrapping modulo N.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (LOG_N+1)'(i);
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found && req_i[cand[LOG_N-1:0]]) begin
        found  = 1'b1;
        winner = cand[LOG_N-1:0];
      end
    end
  end

  always_comb begin
    win_onehot         = '0;
    win_onehot[winner] = 1'b1;
  end

  // A zero weight still buys one packet, so nobody can be granted with no credit.
  assign win_weight = weight_i[int'(winner)*WW +: WW];
  assign win_credit = (win_weight == '0) ? WW'(1) : win_weight;
  assign win_ptr    = (winner == LAST_IDX) ? '0 : winner + 1'b1;

  assign xfer       = (state == LOCK) && req_i[gnt_idx_o] && ready_i;
  assign eop        = xfer && last_i[gnt_idx_o];
  assign credit_dec = (credit == '0) ? '0 : credit - 1'b1;

  always_comb begin
    state_next  = state;
    gnt_next    = gnt_o;
    idx_next    = gnt_idx_o;
    ptr_next    = ptr;
    credit_next = credit;
    case (state)
      IDLE: begin
        if (found) begin
          state_next  = LOCK;
          gnt_next    = win_onehot;
          idx_next    = winner;
          ptr_next    = win_ptr;
          credit_next = win_credit;
        end
      end
      LOCK: begin
        if (eop) begin
          credit_next = credit_dec;
          // Holder still has credit: it keeps the grant and the pointer stays put.
          if ((credit_dec != '0) && req_i[gnt_idx_o]) begin
            state_next = LOCK;
          end else if (found) begin
            state_next  = LOCK;
            gnt_next    = win_onehot;
            idx_next    = winner;
            ptr_next    = win_ptr;
            credit_next = win_credit;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      gnt_o     <= '0;
      gnt_idx_o <= '0;
      ptr       <= '0;
      credit    <= '0;
    end else begin
      state     <= state_next;
      gnt_o     <= gnt_next;
      gnt_idx_o <= idx_next;
      ptr       <= ptr_next;
      credit    <= credit_next;
    end
  end

  assign gnt_valid_o = (state == LOCK);

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed testbench for wrr_arbiter (N=4, WW=4) with hand-computed grant sequences.
module tb_wrr_arbiter;

  localparam int N     = 4;
  localparam int WW    = 4;
  localparam int LOG_N = 2;

  logic              clk;
  logic              rstn;
  logic [N-1:0]      req_i;
  logic [N-1:0]      last_i;
  logic [N*WW-1:0]   weight_i;
  logic              ready_i;
  logic [N-1:0]      gnt_o;
  logic [LOG_N-1:0]  gnt_idx_o;
  logic              gnt_valid_o;

  int passCount;
  int checkCount;

  wrr_arbiter #(.N(N), .WW(WW), .LOG_N(LOG_N)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_i      (req_i),
    .last_i     (last_i),
    .weight_i   (weight_i),
    .ready_i    (ready_i),
    .gnt_o      (gnt_o),
    .gnt_idx_o  (gnt_idx_o),
    .gnt_valid_o(gnt_valid_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] last, input logic ready);
    req_i   = req;
    last_i  = last;
    ready_i = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic checkGrant(input string tag, input int idx);
    logic [N-1:0] onehot;
    onehot      = '0;
    onehot[idx] = 1'b1;
    checkOutput({tag, ".idx"}, 32'(gnt_idx_o), 32'(idx));
    checkOutput({tag, ".gnt"}, 32'(gnt_o), 32'(onehot));
    checkOutput({tag, ".valid"}, 32'(gnt_valid_o), 32'd1);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".gnt"}, 32'(gnt_o), 32'd0);
    checkOutput({tag, ".valid"}, 32'(gnt_valid_o), 32'd0);
  endtask

  task automatic doReset(input logic [N*WW-1:0] weights);
    rstn     = 1'b0;
    req_i    = '0;
    last_i   = '0;
    ready_i  = 1'b0;
    weight_i = weights;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    int expSeq[8];
    passCount  = 0;
    checkCount = 0;

    // Reset values and staying idle with no requests
    doReset(16'h1111);
    checkIdle("reset");
    checkOutput("reset.idx", 32'(gnt_idx_o), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkIdle("idle_noreq");
    checkOutput("idle_noreq.idx", 32'(gnt_idx_o), 32'd0);

    // Equal weights, all requesting, single-beat packets: 0,1,2,3,0
    expSeq = '{0, 1, 2, 3, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 4'b1111, 1'b1);
      checkGrant($sformatf("rr%0d", i), expSeq[i]);
    end

    // weight0=3, weight1=1: 0,0,0,1,0,0,0,1
    doReset(16'h0013);
    expSeq = '{0, 0, 0, 1, 0, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b0011, 4'b1111, 1'b1);
      checkOutput($sformatf("wrr%0d.idx", i), 32'(gnt_idx_o), 32'(expSeq[i]));
    end

    // Four-beat packet on requester 2 with ready toggling, requester 0 arriving mid-packet
    doReset(16'h1111);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    checkGrant("pkt.grant", 2);
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    checkGrant("pkt.b1", 2);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    checkGrant("pkt.w1", 2);
    applyStimulus(4'b0101, 4'b0000, 1'b1);
    checkGrant("pkt.b2", 2);
    applyStimulus(4'b0101, 4'b0100, 1'b0);
    checkGrant("pkt.w2", 2);
    applyStimulus(4'b0101, 4'b0000, 1'b1);
    checkGrant("pkt.b3", 2);
    applyStimulus(4'b0101, 4'b0000, 1'b0);
    checkGrant("pkt.w3", 2);
    applyStimulus(4'b0101, 4'b0100, 1'b1);
    checkGrant("pkt.eop", 0);

    // Holder 1 (weight 2) drops req for 3 cycles; no EOP counted, credit kept
    doReset(16'h0020);
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    checkGrant("drop.grant", 1);
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    checkGrant("drop.b1", 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0001, 4'b1111, 1'b1);
      checkGrant($sformatf("drop.hold%0d", i), 1);
    end
    applyStimulus(4'b0011, 4'b0010, 1'b1);
    checkGrant("drop.eop1", 1);
    applyStimulus(4'b0011, 4'b0010, 1'b1);
    checkGrant("drop.eop2", 0);

    // Asynchronous reset during a grant to requester 3
    doReset(16'h1111);
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    checkGrant("arst.grant", 3);
    #2;
    rstn = 1'b0;
    #1;
    checkIdle("arst.async");
    checkOutput("arst.idx", 32'(gnt_idx_o), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    checkIdle("arst.release");
    applyStimulus(4'b1001, 4'b0000, 1'b0);
    checkGrant("arst.regrant", 0);

    // Zero weights act as one: alternation, then a lone requester regranted each EOP
    doReset(16'h0000);
    expSeq = '{0, 2, 0, 2, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0101, 4'b1111, 1'b1);
      checkOutput($sformatf("w0alt%0d.idx", i), 32'(gnt_idx_o), 32'(expSeq[i]));
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0100, 4'b1111, 1'b1);
      checkGrant($sformatf("w0single%0d", i), 2);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
